// File: rtl/seg14_scan_decoder.sv
// rtl/seg14_scan_decoder.sv - 14-segment scan decoder with shadow/visible character banks
module seg14_scan_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] sel,
  input  logic [13:0] segm,
  input  logic        clear,
  input  logic [3:0]  rd_idx,
  output logic [4:0]  rd_char,
  output logic        frame_valid,
  output logic        frame_done,
  output logic        err_sel,
  output logic        err_seq,
  output logic        err_pat
);

  localparam logic HUNT    = 1'b0;
  localparam logic CAPTURE = 1'b1;

  logic [11:0] sel_q;
  logic [13:0] segm_q;
  logic        state;
  logic [3:0]  e;
  logic [3:0]  l;
  logic [4:0]  shadow  [12];
  logic [4:0]  visible [12];

  logic [4:0]  code;
  logic        pat_bad;
  logic [3:0]  idx;
  logic        sel_any;
  logic        sel_multi;
  logic [4:0]  rd_next;

  always_comb begin
    pat_bad = 1'b0;
    case (segm_q)
      14'b00000000000000: code = 5'd0;
      14'b11101111000000: code = 5'd1;
      14'b10011110000000: code = 5'd2;
      14'b10111101000000: code = 5'd3;
      14'b01101111000000: code = 5'd4;
      14'b10010000010010: code = 5'd5;
      14'b01101100101000: code = 5'd6;
      14'b11111100000000: code = 5'd7;
      14'b10110111000000: code = 5'd8;
      14'b10000000010010: code = 5'd9;
      default: begin
        code    = 5'd31;
        pat_bad = 1'b1;
      end
    endcase
  end

  // Index is only meaningful when sel_q is one-hot; sel_multi gates it otherwise.
  always_comb begin
    idx = 4'd0;
    for (int k = 0; k < 12; k++)
      if (sel_q[k]) idx = 4'(k);
  end

  assign sel_any   = |sel_q;
  assign sel_multi = |(sel_q & (sel_q - 12'd1));

  always_comb begin
    rd_next = 5'd0;
    for (int k = 0; k < 12; k++)
      if (rd_idx == 4'(k)) rd_next = visible[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q       <= '0;
      segm_q      <= '0;
      state       <= HUNT;
      e           <= 4'd0;
      l           <= 4'd0;
      rd_char     <= 5'd0;
      frame_valid <= 1'b0;
      frame_done  <= 1'b0;
      err_sel     <= 1'b0;
      err_seq     <= 1'b0;
      err_pat     <= 1'b0;
      for (int k = 0; k < 12; k++) begin
        shadow[k]  <= 5'd0;
        visible[k] <= 5'd0;
      end
    end else begin
      sel_q      <= sel;
      segm_q     <= segm;
      frame_done <= 1'b0;
      rd_char    <= rd_next;

      // Clear first so a coinciding error event below still wins.
      if (clear) begin
        err_sel <= 1'b0;
        err_seq <= 1'b0;
        err_pat <= 1'b0;
      end

      if (sel_any && sel_multi) begin
        err_sel <= 1'b1;
        state   <= HUNT;
        e       <= 4'd0;
      end else if (sel_any) begin
        if (state == HUNT) begin
          if (idx == 4'd0) begin
            shadow[0] <= code;
            if (pat_bad) err_pat <= 1'b1;
            e     <= 4'd1;
            l     <= 4'd0;
            state <= CAPTURE;
          end
        end else if (idx == e) begin
          shadow[e] <= code;
          l         <= e;
          if (pat_bad) err_pat <= 1'b1;
          if (e == 4'd11) begin
            // Last digit bypasses the shadow so the whole frame lands in one edge.
            for (int k = 0; k < 12; k++)
              visible[k] <= (k == 11) ? code : shadow[k];
            frame_valid <= 1'b1;
            frame_done  <= 1'b1;
            e           <= 4'd0;
          end else begin
            e <= e + 4'd1;
          end
        end else if (idx == l) begin
          shadow[l] <= code;
          if (pat_bad) err_pat <= 1'b1;
        end else begin
          err_seq <= 1'b1;
          state   <= HUNT;
          e       <= 4'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg14_scan_decoder.sv
// tb/tb_seg14_scan_decoder.sv - scoreboard bench for seg14_scan_decoder
module tb_seg14_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] sel;
  logic [13:0] segm;
  logic        clear;
  logic [3:0]  rd_idx;
  logic [4:0]  rd_char;
  logic        frame_valid;
  logic        frame_done;
  logic        err_sel;
  logic        err_seq;
  logic        err_pat;

  seg14_scan_decoder dut (
    .clk(clk), .rst(rst), .sel(sel), .segm(segm), .clear(clear), .rd_idx(rd_idx),
    .rd_char(rd_char), .frame_valid(frame_valid), .frame_done(frame_done),
    .err_sel(err_sel), .err_seq(err_seq), .err_pat(err_pat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total_cnt = 0;
  int fd_q[$];
  int rd_cyc_q[$];
  int rd_exp_q[$];
  int rd_idx_q[$];
  int word[12];

  task automatic chk(string name, int act, int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [13:0] pat(int c);
    case (c)
      0: return 14'b00000000000000;
      1: return 14'b11101111000000;
      2: return 14'b10011110000000;
      3: return 14'b10111101000000;
      4: return 14'b01101111000000;
      5: return 14'b10010000010010;
      6: return 14'b01101100101000;
      7: return 14'b11111100000000;
      8: return 14'b10110111000000;
      9: return 14'b10000000010010;
      default: return 14'b11111111111111;
    endcase
  endfunction

  // Monitor: frame_done pulses and read results are popped from the scoreboard queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) begin
        if (fd_q.size() == 0) chk("frame_done_unexpected_cycle", cyc, -1);
        else chk("frame_done_cycle", cyc, fd_q.pop_front());
      end
      if (rd_cyc_q.size() > 0 && rd_cyc_q[0] == cyc) begin
        int ri;
        void'(rd_cyc_q.pop_front());
        ri = rd_idx_q.pop_front();
        chk($sformatf("rd_char[%0d]", ri), int'(rd_char), rd_exp_q.pop_front());
      end
    end
  end

  task automatic drive(logic [11:0] s, logic [13:0] p);
    sel  = s;
    segm = p;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(int i, int exp);
    rd_idx = 4'(i);
    sel    = 12'd0;
    @(posedge clk);
    #1;
    rd_cyc_q.push_back(cyc);
    rd_exp_q.push_back(exp);
    rd_idx_q.push_back(i);
  endtask

  task automatic run(int first, int last, int hold, bit expect_commit);
    for (int k = first; k <= last; k++)
      for (int h = 0; h < hold; h++) begin
        drive(12'(1 << k), pat(word[k]));
        if (expect_commit && k == 11 && h == 0) fd_q.push_back(cyc + 1);
      end
  endtask

  task automatic chk_flags(string tag, int s, int q, int p);
    chk({tag, "_err_sel"}, int'(err_sel), s);
    chk({tag, "_err_seq"}, int'(err_seq), q);
    chk({tag, "_err_pat"}, int'(err_pat), p);
  endtask

  initial begin
    int c1[12] = '{6, 2, 8, 8, 5, 9, 4, 2, 3, 7, 1, 9};
    int c2[12] = '{1, 9, 2, 8, 4, 7, 6, 5, 3, 8, 2, 9};
    rst = 1'b1; sel = '0; segm = '0; clear = 1'b0; rd_idx = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rd_char", int'(rd_char), 0);
    chk("reset_frame_valid", int'(frame_valid), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    chk_flags("reset", 0, 0, 0);
    rst = 1'b0;

    // Start mid-scan at digit 5, then a full MESSITHEGOAT frame.
    word = c1;
    run(5, 11, 1, 0);
    run(0, 11, 1, 1);
    drive(12'd0, 14'd0);
    for (int k = 0; k < 12; k++) rd(k, c1[k]);
    rd(12, 0);
    rd(15, 0);
    chk("frame_valid_after_commit", int'(frame_valid), 1);
    chk_flags("messithegoat", 0, 0, 0);

    // Back-to-back frame straight from CAPTURE.
    word = c2;
    run(0, 11, 1, 1);
    drive(12'd0, 14'd0);
    rd(0, 1); rd(4, 4); rd(11, 9);

    // Multi-hot select aborts the frame; visible bank keeps the previous frame.
    for (int k = 0; k < 12; k++) word[k] = 7;
    run(0, 4, 1, 0);
    drive(12'b000000000011, pat(7));
    drive(12'd0, 14'd0);
    chk("multihot_err_sel", int'(err_sel), 1);
    run(5, 11, 1, 0);
    drive(12'd0, 14'd0);
    rd(0, 1); rd(3, 8);
    chk_flags("after_multihot", 1, 0, 0);
    clear = 1'b1;
    drive(12'd0, 14'd0);
    clear = 1'b0;
    chk("clear_err_sel", int'(err_sel), 0);
    chk("frame_valid_kept", int'(frame_valid), 1);

    // Unknown pattern on digit 3 is stored as 31 and the frame still commits.
    for (int k = 0; k < 12; k++) word[k] = 0;
    word[3] = 31;
    run(0, 11, 1, 1);
    drive(12'd0, 14'd0);
    chk("bad_pattern_err_pat", int'(err_pat), 1);
    rd(3, 31); rd(2, 0);
    clear = 1'b1;
    drive(12'd0, 14'd0);
    clear = 1'b0;
    chk("clear_err_pat", int'(err_pat), 0);

    // Skip 0,1,3 then a held-digit frame.
    for (int k = 0; k < 12; k++) word[k] = 3;
    run(0, 1, 1, 0);
    drive(12'(1 << 3), pat(3));
    drive(12'd0, 14'd0);
    chk("skip_err_seq", int'(err_seq), 1);
    clear = 1'b1;
    drive(12'd0, 14'd0);
    clear = 1'b0;
    chk("clear_err_seq", int'(err_seq), 0);
    run(0, 11, 3, 1);
    drive(12'd0, 14'd0);
    chk_flags("held", 0, 0, 0);
    rd(7, 3); rd(0, 3);

    // Reset mid-frame while digit 6 sits in the input stage.
    drive(12'b000000000011, 14'd0);
    drive(12'd0, 14'd0);
    chk("pre_reset_err_sel", int'(err_sel), 1);
    word = c1;
    run(0, 6, 1, 0);
    rst = 1'b1;
    drive(12'd0, 14'd0);
    chk("midreset_rd_char", int'(rd_char), 0);
    chk("midreset_frame_valid", int'(frame_valid), 0);
    chk("midreset_frame_done", int'(frame_done), 0);
    chk_flags("midreset", 0, 0, 0);
    rst = 1'b0;
    rd(0, 0);
    run(6, 11, 1, 0);
    run(0, 11, 1, 1);
    drive(12'd0, 14'd0);
    rd(0, 6); rd(11, 9);
    chk_flags("after_reset_frame", 0, 0, 0);

    repeat (3) drive(12'd0, 14'd0);
    chk("frame_done_pending", fd_q.size(), 0);
    chk("rd_pending", rd_cyc_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
